secuenciador_juego: RTL and testbench

SECUENCIADOR_JUEGO -- requirements
Module: secuenciador_juego

---
 rtl/secuenciador_juego_if.sv | 38 +++
 rtl/secuenciador_juego.sv | 164 ++++++++++++++++
 tb/tb_secuenciador_juego.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/secuenciador_juego_if.sv
//==============================================================================
// Module      : secuenciador_juego_if
// Description : Player-input and frog-controller signal bundle of the game
//               sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface secuenciador_juego_if #(
    parameter int TIMER_WIDTH = 8
);
    logic                   SJ_START;
    logic                   SJ_TICK;
    logic                   SJ_RANA_LLEGO;
    logic                   SJ_RANA_CHOCO;
    logic [2:0]             SJ_ESTADO_OUT;
    logic                   SJ_GANO_OUT;
    logic                   SJ_PERDIO_OUT;
    logic [TIMER_WIDTH-1:0] SJ_TIEMPO_OUT;
    logic [1:0]             SJ_RANAS_OUT;
    logic [2:0]             SJ_NIVEL_OUT;
    logic                   SJ_JUGANDO_OUT;
    logic [1:0]             SJ_FIN_OUT;

    modport master (
        output SJ_START, SJ_TICK, SJ_RANA_LLEGO, SJ_RANA_CHOCO,
        input  SJ_ESTADO_OUT, SJ_GANO_OUT, SJ_PERDIO_OUT, SJ_TIEMPO_OUT,
               SJ_RANAS_OUT, SJ_NIVEL_OUT, SJ_JUGANDO_OUT, SJ_FIN_OUT
    );

    modport slave (
        input  SJ_START, SJ_TICK, SJ_RANA_LLEGO, SJ_RANA_CHOCO,
        output SJ_ESTADO_OUT, SJ_GANO_OUT, SJ_PERDIO_OUT, SJ_TIEMPO_OUT,
               SJ_RANAS_OUT, SJ_NIVEL_OUT, SJ_JUGANDO_OUT, SJ_FIN_OUT
    );
endinterface

`default_nettype wire

// File: rtl/secuenciador_juego.sv
//==============================================================================
// Module      : secuenciador_juego
// Description : Game sequencer - launches frogs, runs the per-frog countdown,
//               scores saves/losses, tracks level and holds the game result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module secuenciador_juego #(
    parameter int TIMER_WIDTH = 8,
    parameter int TIEMPO_RANA = 100,
    parameter int PASO_NIVEL  = 8,
    parameter int NIVEL_MAX   = 7,
    parameter int HOLD_TICKS  = 4
) (
    input  logic                 SJ_CLOCK_50,
    input  logic                 SJ_RESET_InLow,
    secuenciador_juego_if.slave  sj
);

    localparam int                 c_HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [2:0]         c_NIVEL_MAX = 3'(NIVEL_MAX);

    if (TIEMPO_RANA <= PASO_NIVEL * NIVEL_MAX) begin : g_param_check
        $error("secuenciador_juego: TIEMPO_RANA must exceed PASO_NIVEL*NIVEL_MAX");
    end

    typedef enum logic [2:0] {
        REPOSO         = 3'd0,
        LANZA          = 3'd1,
        JUGANDO        = 3'd2,
        ANOTA          = 3'd3,
        FALLA          = 3'd4,
        MOSTRAR_GANO   = 3'd5,
        MOSTRAR_PERDIO = 3'd6
    } estado_t;

    estado_t                r_estado;
    estado_t                w_estado_sig;
    logic                   r_start_q;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [1:0]             r_ranas;
    logic [2:0]             r_nivel;
    logic [c_HOLD_W-1:0]    r_hold;
    logic                   w_start_evt;
    logic                   w_hold_fin;
    logic [TIMER_WIDTH-1:0] w_recarga;

    assign w_start_evt = sj.SJ_START & ~r_start_q;
    assign w_hold_fin  = sj.SJ_TICK && (r_hold == c_HOLD_LAST);
    assign w_recarga   = TIMER_WIDTH'(TIEMPO_RANA) - TIMER_WIDTH'(PASO_NIVEL * int'(r_nivel));

    // Reset value 1 keeps a button held through reset from looking like a press.
    always_ff @(posedge SJ_CLOCK_50 or negedge SJ_RESET_InLow) begin
        if (!SJ_RESET_InLow) begin
            r_start_q <= 1'b1;
        end else begin
            r_start_q <= sj.SJ_START;
        end
    end

    always_ff @(posedge SJ_CLOCK_50 or negedge SJ_RESET_InLow) begin
        if (!SJ_RESET_InLow) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig       = r_estado;
        sj.SJ_ESTADO_OUT   = 3'b000;
        sj.SJ_GANO_OUT     = 1'b0;
        sj.SJ_PERDIO_OUT   = 1'b0;
        sj.SJ_JUGANDO_OUT  = 1'b0;
        sj.SJ_FIN_OUT      = 2'b00;
        case (r_estado)
            REPOSO: begin
                if (w_start_evt) w_estado_sig = LANZA;
            end
            LANZA: begin
                sj.SJ_ESTADO_OUT  = 3'b111;
                sj.SJ_JUGANDO_OUT = 1'b1;
                w_estado_sig      = JUGANDO;
            end
            JUGANDO: begin
                sj.SJ_JUGANDO_OUT = 1'b1;
                // A crash outranks a simultaneous arrival.
                if (sj.SJ_RANA_CHOCO || (r_timer == '0)) begin
                    w_estado_sig = FALLA;
                end else if (sj.SJ_RANA_LLEGO) begin
                    w_estado_sig = ANOTA;
                end
            end
            ANOTA: begin
                sj.SJ_GANO_OUT    = 1'b1;
                sj.SJ_JUGANDO_OUT = 1'b1;
                w_estado_sig      = (r_ranas == 2'd2) ? MOSTRAR_GANO : JUGANDO;
            end
            FALLA: begin
                sj.SJ_PERDIO_OUT = 1'b1;
                w_estado_sig     = MOSTRAR_PERDIO;
            end
            MOSTRAR_GANO: begin
                sj.SJ_FIN_OUT = 2'b01;
                if (w_hold_fin) w_estado_sig = REPOSO;
            end
            MOSTRAR_PERDIO: begin
                sj.SJ_FIN_OUT = 2'b10;
                if (w_hold_fin) w_estado_sig = REPOSO;
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    always_ff @(posedge SJ_CLOCK_50 or negedge SJ_RESET_InLow) begin
        if (!SJ_RESET_InLow) begin
            r_timer <= '0;
            r_ranas <= 2'd0;
            r_nivel <= 3'd0;
            r_hold  <= '0;
        end else begin
            case (r_estado)
                LANZA: begin
                    r_ranas <= 2'd0;
                    r_timer <= w_recarga;
                end
                JUGANDO: begin
                    if (sj.SJ_TICK && (r_timer != '0)) begin
                        r_timer <= r_timer - TIMER_WIDTH'(1);
                    end
                end
                ANOTA: begin
                    // Reload ignores any tick arriving in this cycle.
                    r_ranas <= r_ranas + 2'd1;
                    r_timer <= w_recarga;
                    if ((r_ranas == 2'd2) && (r_nivel != c_NIVEL_MAX)) begin
                        r_nivel <= r_nivel + 3'd1;
                    end
                end
                FALLA: begin
                    r_nivel <= 3'd0;
                end
                MOSTRAR_GANO, MOSTRAR_PERDIO: begin
                    if (sj.SJ_TICK) begin
                        r_hold <= w_hold_fin ? '0 : r_hold + c_HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sj.SJ_TIEMPO_OUT = r_timer;
    assign sj.SJ_RANAS_OUT  = r_ranas;
    assign sj.SJ_NIVEL_OUT  = r_nivel;

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_juego.sv
//==============================================================================
// Module      : tb_secuenciador_juego
// Description : Self-checking bench for secuenciador_juego with an event
//               scoreboard for launch/save/loss pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_secuenciador_juego;

    localparam int TW = 8;
    localparam logic [4:0] c_EV_LANZA  = 5'b111_0_0;
    localparam logic [4:0] c_EV_GANO   = 5'b000_1_0;
    localparam logic [4:0] c_EV_PERDIO = 5'b000_0_1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_nivel = 0;
    int   exp_ranas = 0;
    logic [4:0] q_evt[$];
    logic [4:0] w_obs;

    always #5 clk = ~clk;

    secuenciador_juego_if #(.TIMER_WIDTH(TW)) sj ();

    secuenciador_juego #(
        .TIMER_WIDTH(TW), .TIEMPO_RANA(100), .PASO_NIVEL(8),
        .NIVEL_MAX(7), .HOLD_TICKS(4)
    ) dut (
        .SJ_CLOCK_50    (clk),
        .SJ_RESET_InLow (rst_n),
        .sj             (sj)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pulse the DUT produces must match the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            w_obs = {sj.SJ_ESTADO_OUT, sj.SJ_GANO_OUT, sj.SJ_PERDIO_OUT};
            if (w_obs != 5'd0) begin
                if (q_evt.size() == 0) chk("evt_unexpected", 32'(w_obs), 32'd0);
                else                   chk("evt", 32'(w_obs), 32'(q_evt.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sj.SJ_TICK = 1'b1;
        cyc();
        sj.SJ_TICK = 1'b0;
    endtask

    function automatic int recarga(input int nivel);
        return 100 - 8 * nivel;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({sj.SJ_ESTADO_OUT, sj.SJ_GANO_OUT, sj.SJ_PERDIO_OUT, sj.SJ_TIEMPO_OUT,
                      sj.SJ_RANAS_OUT, sj.SJ_NIVEL_OUT, sj.SJ_JUGANDO_OUT, sj.SJ_FIN_OUT}), 32'd0);
    endtask

    task automatic lanzar();
        q_evt.push_back(c_EV_LANZA);
        sj.SJ_START = 1'b1;
        cyc();
        chk("lanza_estado", 32'(sj.SJ_ESTADO_OUT), 32'd7);
        cyc();
        sj.SJ_START = 1'b0;
        exp_ranas = 0;
        chk("lanza_tiempo", 32'(sj.SJ_TIEMPO_OUT), 32'(recarga(exp_nivel)));
        chk("lanza_jugando", 32'(sj.SJ_JUGANDO_OUT), 32'd1);
        chk("lanza_ranas", 32'(sj.SJ_RANAS_OUT), 32'd0);
    endtask

    task automatic anotar(input logic tick_en_anota);
        q_evt.push_back(c_EV_GANO);
        sj.SJ_RANA_LLEGO = 1'b1;
        cyc();
        sj.SJ_RANA_LLEGO = 1'b0;
        chk("anota_gano", 32'(sj.SJ_GANO_OUT), 32'd1);
        sj.SJ_TICK = tick_en_anota;
        cyc();
        sj.SJ_TICK = 1'b0;
        exp_ranas++;
        chk("anota_ranas", 32'(sj.SJ_RANAS_OUT), 32'(exp_ranas));
        if (exp_ranas == 3) begin
            exp_nivel = (exp_nivel < 7) ? exp_nivel + 1 : 7;
            chk("gano_fin", 32'(sj.SJ_FIN_OUT), 32'd1);
            chk("gano_nivel", 32'(sj.SJ_NIVEL_OUT), 32'(exp_nivel));
        end else begin
            chk("anota_tiempo", 32'(sj.SJ_TIEMPO_OUT), 32'(recarga(exp_nivel)));
        end
    endtask

    task automatic mostrar(input int fin);
        for (int i = 0; i < 4; i++) begin
            chk("mostrar_fin", 32'(sj.SJ_FIN_OUT), 32'(fin));
            chk("mostrar_ranas", 32'(sj.SJ_RANAS_OUT), 32'(exp_ranas));
            tick();
        end
        chk("reposo_fin", 32'(sj.SJ_FIN_OUT), 32'd0);
        chk("reposo_jugando", 32'(sj.SJ_JUGANDO_OUT), 32'd0);
        chk("reposo_ranas", 32'(sj.SJ_RANAS_OUT), 32'(exp_ranas));
    endtask

    task automatic perder_resto();
        cyc();
        chk("falla_perdio", 32'(sj.SJ_PERDIO_OUT), 32'd1);
        chk("falla_gano", 32'(sj.SJ_GANO_OUT), 32'd0);
        cyc();
        exp_nivel = 0;
        chk("perdio_fin", 32'(sj.SJ_FIN_OUT), 32'd2);
        chk("perdio_nivel", 32'(sj.SJ_NIVEL_OUT), 32'd0);
        mostrar(2);
    endtask

    initial begin
        sj.SJ_START      = 1'b0;
        sj.SJ_TICK       = 1'b0;
        sj.SJ_RANA_LLEGO = 1'b0;
        sj.SJ_RANA_CHOCO = 1'b0;
        #12;
        chk_all_zero("reset_outputs");
        cyc();
        rst_n = 1'b1;
        cyc();

        // Launch at level 0, countdown, reload priority over a tick in ANOTA, three saves.
        lanzar();
        tick(); tick(); tick();
        chk("tick_tiempo", 32'(sj.SJ_TIEMPO_OUT), 32'd97);
        anotar(1'b1);
        repeat (8) cyc();
        anotar(1'b0);
        repeat (8) cyc();
        anotar(1'b0);
        mostrar(1);
        chk("nivel_persist", 32'(sj.SJ_NIVEL_OUT), 32'd1);
        lanzar();

        // Simultaneous arrival and crash: crash wins.
        q_evt.push_back(c_EV_PERDIO);
        sj.SJ_RANA_LLEGO = 1'b1;
        sj.SJ_RANA_CHOCO = 1'b1;
        cyc();
        sj.SJ_RANA_LLEGO = 1'b0;
        sj.SJ_RANA_CHOCO = 1'b0;
        chk("choco_perdio", 32'(sj.SJ_PERDIO_OUT), 32'd1);
        chk("choco_gano", 32'(sj.SJ_GANO_OUT), 32'd0);
        cyc();
        exp_nivel = 0;
        chk("choco_fin", 32'(sj.SJ_FIN_OUT), 32'd2);
        chk("choco_nivel", 32'(sj.SJ_NIVEL_OUT), 32'd0);
        mostrar(2);

        // Timeout after 100 ticks.
        lanzar();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 49) chk("timeout_mid", 32'(sj.SJ_TIEMPO_OUT), 32'd50);
        end
        chk("timeout_cero", 32'(sj.SJ_TIEMPO_OUT), 32'd0);
        chk("timeout_jugando", 32'(sj.SJ_JUGANDO_OUT), 32'd1);
        q_evt.push_back(c_EV_PERDIO);
        perder_resto();

        // Eight wins in a row: level saturates.
        for (int g = 0; g < 8; g++) begin
            lanzar();
            for (int f = 0; f < 3; f++) begin
                anotar(1'b0);
                cyc();
            end
            mostrar(1);
        end
        chk("nivel_sat", 32'(sj.SJ_NIVEL_OUT), 32'd7);
        lanzar();
        chk("recarga_44", 32'(sj.SJ_TIEMPO_OUT), 32'd44);

        // Reset mid-game aborts at once, without waiting for a clock edge.
        anotar(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_game");
        exp_nivel = 0;
        exp_ranas = 0;

        // START held through reset release must not launch.
        sj.SJ_START = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("held_start_jugando", 32'(sj.SJ_JUGANDO_OUT), 32'd0);
        sj.SJ_START = 1'b0;
        cyc();
        lanzar();
        repeat (2) cyc();

        chk("scoreboard_vacio", 32'(q_evt.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
